mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-ported unified memory between instruction fetch (IF) and data access (MEM stage: lw/sw) of the pipelined core. Each side sees a level request / one-cycle valid handshake; the memory side uses a request/ready issue handshake with a later rvalid response, one transaction outstanding. Data has priority, with a starvation limit that forces a fetch grant. It drives the fetch and memory stall inputs of the hazard unit.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch is pending; range 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held until i_valid
- i_addr  in  ADDR_W  fetch address, stable while i_req
- i_valid  out  1  one-cycle fetch completion
- i_rdata  out  DATA_W  fetched instruction, valid with i_valid
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_valid  out  1  one-cycle data completion, for loads and stores
- d_rdata  out  DATA_W  load data, valid with d_valid
- mem_req  out  1  issue request to memory
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response (read data or write ack)
- mem_rdata  in  DATA_W  read data
- stall_f  out  1  fetch stall
- stall_m  out  1  MEM-stage stall

## Operation
- Reset: state IDLE, owner = fetch, streak = 0; mem_req, mem_we, i_valid, d_valid = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate. If only one request is present, grant it. If both are present, grant data unless streak == MAX_D_STREAK, in which case grant fetch. On grant, register owner and mem_addr/mem_we/mem_wdata, then go to ISSUE. Fetch grants drive mem_we = 0 and mem_wdata = 0. With no request, stay in IDLE.
- Streak update at grant time:
  - Fetch grant: streak = 0.
  - Data grant with i_req = 1: streak = streak + 1, saturating.
  - Data grant with i_req = 0: streak = 0.
- ISSUE: mem_req = 1 and the memory fields are held stable. If mem_ready = 1, go to WAIT and drop mem_req next cycle. Otherwise stay in ISSUE.
- WAIT: mem_req = 0. On mem_rvalid, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP: the owner's valid = 1 for exactly this cycle, then go to IDLE. The other side's valid stays 0.
- i_rdata/d_rdata: hold their last captured value until the next capture for that side. d_rdata is also captured on store acks.
- mem_rvalid outside WAIT is ignored. mem_ready outside ISSUE is ignored.
- stall_f = i_req & ~i_valid; stall_m = d_req & ~d_valid. Both are combinational.
- Requesters may change req/addr in the cycle after their valid. RESP → IDLE guarantees the completed request is never re-granted.
- Reset mid-transaction: rst wins over all transitions and returns to IDLE next edge. The memory must also be reset; a stale rvalid after reset is ignored because the block is in IDLE.

## Timing
- Minimum latency, with the request seen in IDLE at cycle t:
  - t+1: ISSUE, mem_req = 1; mem_ready arrives in this cycle.
  - t+2: WAIT; mem_rvalid arrives in this cycle.
  - t+3: RESP, valid pulse.
  - t+4: IDLE, next arbitration.
- Each extra cycle of mem_ready or mem_rvalid delay adds one cycle of latency.
- Back-to-back throughput: one transaction per 4 cycles at best.
- mem_* outputs are registered; only stall_f/stall_m are combinational.

## Test plan
- Single fetch: i_req = 1, i_addr = 0x100; mem_ready at first ISSUE cycle; mem_rvalid next cycle with mem_rdata = 0x00500093. Expect mem_req for exactly 1 cycle with mem_addr = 0x100 and mem_we = 0; i_valid at t+3 with i_rdata = 0x00500093; stall_f high t..t+2, low at t+3; d_valid never asserts.
- Simultaneous requests: i_req and d_req (store, d_addr = 0x2000, d_wdata = 0xDEADBEEF) both high in IDLE. Expect data served first (mem_we = 1, mem_addr = 0x2000), d_valid, then fetch issued at next IDLE; i_valid follows.
- Starvation: d_req held continuously (re-presented after each d_valid) and i_req held; MAX_D_STREAK = 4. Expect exactly 4 data transactions, then 1 fetch, then the pattern repeats.
- Backpressure: mem_ready low for 3 cycles, mem_rvalid delayed 5 cycles. Expect mem_req, mem_addr and mem_wdata stable through ISSUE; valid exactly 1 cycle after rvalid; stall held throughout.
- Spurious and reset: mem_rvalid pulsed in IDLE, producing no valid. Then rst asserted in WAIT: expect IDLE next cycle, all outputs at reset values, and a following mem_rvalid ignored.
- Load data: d_req load at 0x3000, mem_rdata = 0x12345678. Expect d_rdata = 0x12345678 with d_valid, and i_rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// MEM-stage data access. Data wins ties, but a data streak cap forces a fetch grant.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m
);

  // Handshakes: a requester holds req (and its fields) until its one-cycle
  // valid; the memory accepts when mem_req & mem_ready, and answers with a
  // single mem_rvalid later. Only one memory transaction is ever outstanding.

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  state_t     state, state_next;
  logic       owner_d;
  logic [3:0] streak;
  logic       grant_d, grant_i;

  // Data wins unless fetch is waiting and data has already had its full run.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_req && (!i_req || streak != MAX_S)) begin
      grant_d = 1'b1;
    end else if (i_req) begin
      grant_i = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_d || grant_i) state_next = ISSUE;
      ISSUE:   if (mem_ready) state_next = WAIT;
      WAIT:    if (mem_rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d   <= 1'b0;
      streak    <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d   <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!i_req) begin
              streak <= 4'd0;
            end else if (streak != 4'hF) begin
              streak <= streak + 4'd1;
            end
          end else if (grant_i) begin
            owner_d   <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            streak    <= 4'd0;
          end
        end
        ISSUE: begin
          if (mem_ready) mem_req <= 1'b0;
        end
        WAIT: begin
          // Store acks also land in d_rdata.
          if (mem_rvalid) begin
            if (owner_d) begin
              d_rdata <= mem_rdata;
              d_valid <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_f = i_req & ~i_valid;
  assign stall_m = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized fetch/data traffic,
// checked by a scoreboard fed from a sparse-memory reference model.
module tb_mem_arbiter;

  localparam int MAX_D = 4;

  logic        clk, rst;
  logic        i_req, i_valid, d_req, d_we, d_valid;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_f, stall_m;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAX_D)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] glog_addr[$];
  logic        glog_we[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] mem_arr   [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  // ---------------- memory responder ----------------
  logic        rsp_auto;
  int          ready_max, rvalid_max;
  logic        auto_ready, auto_rvalid, man_ready, man_rvalid;
  logic [31:0] auto_rdata, man_rdata;
  logic [31:0] rsp_a, rsp_wd;
  logic        rsp_w;

  assign mem_ready  = rsp_auto ? auto_ready  : man_ready;
  assign mem_rvalid = rsp_auto ? auto_rvalid : man_rvalid;
  assign mem_rdata  = rsp_auto ? auto_rdata  : man_rdata;

  initial begin
    auto_ready = 1'b0; auto_rvalid = 1'b0; auto_rdata = '0;
    forever begin
      @(negedge clk);
      if (rsp_auto && mem_req && !rst) begin
        repeat ($urandom_range(0, ready_max)) @(negedge clk);
        auto_ready = 1'b1;
        rsp_a = mem_addr; rsp_w = mem_we; rsp_wd = mem_wdata;
        @(negedge clk);
        auto_ready = 1'b0;
        repeat ($urandom_range(0, rvalid_max)) @(negedge clk);
        if (rsp_w) begin
          mem_arr[rsp_a] = rsp_wd;
          auto_rdata = ~rsp_wd;   // store ack carries the inverted write data
        end else begin
          auto_rdata = mem_arr.exists(rsp_a) ? mem_arr[rsp_a] : init_word(rsp_a);
        end
        auto_rvalid = 1'b1;
        @(negedge clk);
        auto_rvalid = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        mon_prev_req, mon_prev_we, mon_prev_iv, mon_prev_dv;
  logic [31:0] mon_prev_addr, mon_prev_wdata;
  int          mon_run;
  logic        mon_is_d, mon_exp_d;

  initial begin
    mon_prev_req = 1'b0; mon_prev_iv = 1'b0; mon_prev_dv = 1'b0; mon_run = 0;
    mon_prev_we = 1'b0; mon_prev_addr = '0; mon_prev_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mon_run = 0; mon_prev_req = 1'b0; mon_prev_iv = 1'b0; mon_prev_dv = 1'b0;
      end else begin
        chk("stall_f", stall_f, i_req & ~i_valid);
        chk("stall_m", stall_m, d_req & ~d_valid);
        chk("i_valid_pulse", i_valid & mon_prev_iv, 1'b0);
        chk("d_valid_pulse", d_valid & mon_prev_dv, 1'b0);
        chk("both_valid", i_valid & d_valid, 1'b0);
        if (i_valid) begin
          checks++;
          if (exp_i_q.size() == 0) begin
            errors++;
            $display("FAIL i_valid_unexpected: got i_rdata %h with nothing outstanding", i_rdata);
          end else begin
            chk("i_rdata", i_rdata, exp_i_q.pop_front());
          end
        end
        if (d_valid) begin
          checks++;
          if (exp_d_q.size() == 0) begin
            errors++;
            $display("FAIL d_valid_unexpected: got d_rdata %h with nothing outstanding", d_rdata);
          end else begin
            chk("d_rdata", d_rdata, exp_d_q.pop_front());
          end
        end
        if (mem_req && mon_prev_req) begin
          chk("issue_addr_stable", mem_addr, mon_prev_addr);
          chk("issue_we_stable", mem_we, mon_prev_we);
          chk("issue_wdata_stable", mem_wdata, mon_prev_wdata);
        end
        if (mem_req && !mon_prev_req) begin
          // A new grant was made at this edge from the requests seen now.
          mon_is_d  = (mem_addr >= 32'h2000);
          mon_exp_d = (i_req && d_req) ? (mon_run < MAX_D) : d_req;
          chk("grant_side", mon_is_d, mon_exp_d);
          if (!mon_is_d) chk("fetch_grant_wdata", {mem_wdata[31:1], mem_we}, 32'h0);
          mon_run = (mon_is_d && i_req) ? mon_run + 1 : 0;
          glog_addr.push_back(mem_addr);
          glog_we.push_back(mem_we);
        end
        mon_prev_req = mem_req; mon_prev_we = mem_we;
        mon_prev_addr = mem_addr; mon_prev_wdata = mem_wdata;
        mon_prev_iv = i_valid; mon_prev_dv = d_valid;
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic fetch_txn(input logic [31:0] addr);
    int n;
    exp_i_q.push_back(model_read(addr));
    i_req = 1'b1; i_addr = addr;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!i_valid && n < 200);
    if (!i_valid) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: no i_valid for addr %h within 200 cycles", addr);
    end
    @(negedge clk);
    i_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    if (we) begin
      model_mem[addr] = wdata;
      exp_d_q.push_back(~wdata);
    end else begin
      exp_d_q.push_back(model_read(addr));
    end
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!d_valid && n < 200);
    if (!d_valid) begin
      checks++; errors++;
      $display("FAIL data_timeout: no d_valid for addr %h within 200 cycles", addr);
    end
    @(negedge clk);
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_i_valid"}, i_valid, 1'b0);
    chk({tag, "_d_valid"}, d_valid, 1'b0);
    chk({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] saved;

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    rsp_auto = 1'b1; ready_max = 0; rvalid_max = 0;
    man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
    model_mem[32'h100]  = 32'h00500093; mem_arr[32'h100]  = 32'h00500093;
    model_mem[32'h3000] = 32'h12345678; mem_arr[32'h3000] = 32'h12345678;

    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    chk("reset_stall_f", stall_f, 1'b0);
    chk("reset_stall_m", stall_m, 1'b0);
    rst = 1'b0;

    // Single fetch at minimum latency.
    @(negedge clk);
    exp_i_q.push_back(32'h00500093);
    i_req = 1'b1; i_addr = 32'h100;
    #1 chk("sf_stall_t0", stall_f, 1'b1);
    @(posedge clk); #1;
    chk("sf_mem_req_t1", mem_req, 1'b1);
    chk("sf_mem_addr", mem_addr, 32'h100);
    chk("sf_mem_we", mem_we, 1'b0);
    chk("sf_stall_t1", stall_f, 1'b1);
    @(posedge clk); #1;
    chk("sf_mem_req_t2", mem_req, 1'b0);
    chk("sf_stall_t2", stall_f, 1'b1);
    @(posedge clk); #1;
    chk("sf_i_valid_t3", i_valid, 1'b1);
    chk("sf_i_rdata", i_rdata, 32'h00500093);
    chk("sf_stall_t3", stall_f, 1'b0);
    chk("sf_d_valid", d_valid, 1'b0);
    @(negedge clk);
    i_req = 1'b0;
    @(posedge clk); #1;
    chk("sf_i_valid_t4", i_valid, 1'b0);

    // Simultaneous fetch and store: data goes first.
    @(negedge clk);
    glog_addr.delete(); glog_we.delete();
    fork
      fetch_txn(32'h104);
      data_txn(1'b1, 32'h2000, 32'hDEADBEEF);
    join
    chk("sim_grants", glog_addr.size(), 2);
    chk("sim_first_addr", glog_addr[0], 32'h2000);
    chk("sim_first_we", glog_we[0], 1'b1);
    chk("sim_second_addr", glog_addr[1], 32'h104);
    chk("sim_second_we", glog_we[1], 1'b0);

    // Starvation: continuous fetch and data requests.
    do_reset();
    ready_max = 1; rvalid_max = 1;
    glog_addr.delete(); glog_we.delete();
    fork
      begin
        for (int k = 0; k < 2; k++) fetch_txn(32'h200 + 32'(4 * k));
      end
      begin
        for (int k = 0; k < 8; k++) data_txn(k[0], 32'h2000 + 32'(4 * (k % 8)), $urandom);
      end
    join
    chk("starve_grants", glog_addr.size(), 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("starve_seq_%0d", k), glog_addr[k] >= 32'h2000, (k % 5) != 4);
    end

    // Backpressure: ready low for 3 ISSUE cycles, rvalid 5 cycles late.
    rsp_auto = 1'b0;
    @(negedge clk);
    model_mem[32'h2008] = 32'hCAFEF00D; mem_arr[32'h2008] = 32'hCAFEF00D;
    exp_d_q.push_back(~32'hCAFEF00D);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2008; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_mem_req", mem_req, 1'b1);
      chk("bp_mem_addr", mem_addr, 32'h2008);
      chk("bp_mem_wdata", mem_wdata, 32'hCAFEF00D);
      chk("bp_stall_issue", stall_m, 1'b1);
      if (k < 3) begin @(posedge clk); #1; end
    end
    @(negedge clk); man_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_req_dropped", mem_req, 1'b0);
    @(negedge clk); man_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_no_valid_wait", d_valid, 1'b0);
      chk("bp_stall_wait", stall_m, 1'b1);
    end
    @(negedge clk); man_rvalid = 1'b1; man_rdata = ~32'hCAFEF00D;
    @(posedge clk); #1;
    chk("bp_d_valid", d_valid, 1'b1);
    chk("bp_d_rdata", d_rdata, ~32'hCAFEF00D);
    @(negedge clk); man_rvalid = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    chk("bp_d_valid_drop", d_valid, 1'b0);

    // Spurious rvalid while idle.
    @(negedge clk); man_rvalid = 1'b1; man_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("spur_i_valid", i_valid, 1'b0);
    chk("spur_d_valid", d_valid, 1'b0);
    @(negedge clk); man_rvalid = 1'b0;
    @(posedge clk); #1;
    chk("spur_i_valid2", i_valid, 1'b0);
    chk("spur_d_valid2", d_valid, 1'b0);
    chk("spur_mem_req", mem_req, 1'b0);
    chk("spur_d_rdata_held", d_rdata, ~32'hCAFEF00D);
    chk("spur_i_rdata_held", i_rdata, model_read(32'h204));

    // Reset while waiting for the response; a late rvalid must be ignored.
    @(negedge clk); i_req = 1'b1; i_addr = 32'h180;
    @(posedge clk); #1;
    chk("rw_issue", mem_req, 1'b1);
    @(negedge clk); man_ready = 1'b1;
    @(posedge clk); #1;
    chk("rw_wait", mem_req, 1'b0);
    @(negedge clk); man_ready = 1'b0; rst = 1'b1; i_req = 1'b0;
    @(posedge clk); #1;
    chk_reset_values("rw");
    @(negedge clk); rst = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    chk("rw_stale_i_valid", i_valid, 1'b0);
    chk("rw_stale_i_rdata", i_rdata, 32'h0);
    @(negedge clk); man_rvalid = 1'b0;
    @(posedge clk); #1;
    chk("rw_stale_i_valid2", i_valid, 1'b0);
    chk("rw_idle", mem_req, 1'b0);

    // Load data leaves the fetch data register alone.
    rsp_auto = 1'b1; ready_max = 0; rvalid_max = 0;
    @(negedge clk);
    fetch_txn(32'h1F0);
    saved = i_rdata;
    chk("ld_prefetch", saved, model_read(32'h1F0));
    data_txn(1'b0, 32'h3000, 32'h0);
    chk("ld_d_rdata", d_rdata, 32'h12345678);
    chk("ld_i_rdata_kept", i_rdata, saved);

    // Randomized mixed traffic with random memory latency.
    ready_max = 3; rvalid_max = 4;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          fetch_txn(32'h100 + 32'(4 * $urandom_range(0, 63)));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          data_txn(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 7)), $urandom);
        end
      end
    join

    repeat (4) @(negedge clk);
    chk("exp_i_q_drained", exp_i_q.size(), 0);
    chk("exp_d_q_drained", exp_d_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
